mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic PORT_I          = 1'b0;
    localparam logic PORT_D          = 1'b1;
    localparam int   DEFAULT_TIMEOUT = 64;
    localparam int   BE_WIDTH        = 4;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Busy-cycle counter for the arbiter: cleared while idle, flags the last allowed cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data port arbiter onto a single memory bus; one transaction in flight,
// round-robin on contention, timeout reported through err alongside ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [BE_WIDTH-1:0]   d_be,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [BE_WIDTH-1:0]   m_be,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ack,
    output logic                  err,
    output logic                  stall_if,
    output logic                  stall_mem
);

    state_t state;
    logic   gnt;
    logic   last_gnt;
    logic   timed_out;
    logic   expired;
    logic   busy;
    logic   i_pend;
    logic   d_pend;
    logic   pick;

    // A port whose ready is showing this cycle is still holding req; don't re-grant it.
    assign i_pend = i_req & ~i_ready;
    assign d_pend = d_req & ~d_ready;
    assign busy   = (state == BUSY_I) || (state == BUSY_D);

    always_comb begin
        pick = PORT_I;
        if (i_pend && d_pend) begin
            pick = (last_gnt == PORT_I) ? PORT_D : PORT_I;
        end else if (d_pend) begin
            pick = PORT_D;
        end
    end

    assign stall_if  = rst_n & i_req & ~i_ready;
    assign stall_mem = rst_n & d_req & ~d_ready;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == IDLE),
        .en      (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= PORT_I;
            last_gnt  <= PORT_I;
            timed_out <= 1'b0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_be      <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        gnt       <= pick;
                        timed_out <= 1'b0;
                        m_req     <= 1'b1;
                        if (pick == PORT_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                            state   <= BUSY_D;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_be    <= '1;
                            state   <= BUSY_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Ack wins over a simultaneous expiry.
                    if (m_ack) begin
                        if (!m_we) begin
                            if (state == BUSY_D) d_rdata <= m_rdata;
                            else                 i_rdata <= m_rdata;
                        end
                        m_req <= 1'b0;
                        state <= RESP;
                    end else if (expired) begin
                        if (state == BUSY_D) d_rdata <= '0;
                        else                 i_rdata <= '0;
                        timed_out <= 1'b1;
                        m_req     <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (gnt == PORT_D) d_ready <= 1'b1;
                    else               i_ready <= 1'b1;
                    err      <= timed_out;
                    last_gnt <= gnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
